host_io_mailbox: RTL and testbench

- Synthesisable memory-mapped host-I/O slave on the core data bus (req/gnt/rvalid protocol). Generalises single-channel putchar/tohost bench monitoring to NUM_CHAN buffered character channels plus a sticky exit-code register.
- Characters drain to one valid/ready stream via round-robin arbitration.
- Sits beside sim_memory behind the top-level address decoder. Usable in simulation and FPGA bring-up.

---
 rtl/host_io_pkg.sv | 22 ++
 rtl/host_io_fifo.sv | 53 +++++
 rtl/host_io_mailbox.sv | 185 ++++++++++++++++++
 tb/tb_host_io_mailbox.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/host_io_pkg.sv
// Shared definitions for the host I/O mailbox: register offsets, arbiter states, FIFO entry layout.
// The timestamp field only exists when HOST_IO_TIMESTAMP_EN is defined.
package host_io_pkg;

  localparam logic [11:0] TOHOST_OFF   = 12'h000;
  localparam logic [11:0] STATUS_OFF   = 12'h004;
  localparam logic [11:0] EXITCODE_OFF = 12'h008;
  localparam logic [11:0] PUTCHAR_OFF  = 12'h010;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  typedef struct packed {
`ifdef HOST_IO_TIMESTAMP_EN
    logic [31:0] ts;
`endif
    logic [7:0]  char;
  } fifo_entry_t;

endpackage

// File: rtl/host_io_fifo.sv
// Generic synchronous FIFO with occupancy count and a one-cycle-delayed full flag.
// Latency: push visible at pop_dat the cycle after the push edge.
// Backpressure: push into a full FIFO is dropped unless a pop happens in the same cycle.
module host_io_fifo #(
  parameter int  DEPTH = 8,
  parameter int  WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNTW  = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic [CNTW-1:0]  count,
  output logic             full,
  output logic             empty,
  output logic             full_q
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNTW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count  <= count + CNTW'(do_push) - CNTW'(do_pop);
      // Lags full by one cycle so the freed slot is only advertised a cycle later.
      full_q <= full;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/host_io_mailbox.sv
// Host I/O mailbox slave: NUM_CHAN putchar FIFOs, sticky exit code, round-robin character stream.
// Latency: bus response 1 cycle after grant; push to out_valid_o 2 cycles, one bubble between offers.
// Backpressure: PUTCHAR to a full channel holds data_gnt_o low; stream holds while out_ready_i low. Option: HOST_IO_TIMESTAMP_EN.
module host_io_mailbox
  import host_io_pkg::*;
#(
  parameter int          NUM_CHAN   = 2,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
  localparam int         CW         = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1,
  localparam int         CNTW       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          data_req_i,
  input  logic [31:0]   data_addr_i,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [31:0]   data_wdata_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  output logic [31:0]   data_rdata_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [CW-1:0] out_chan_o,
  output logic [7:0]    out_char_o,
  output logic [31:0]   out_ts_o,
  output logic          exit_valid_o,
  output logic [31:0]   exit_code_o
);

  logic [11:0]         off;
  logic                hit;
  logic [11:0]         put_idx;
  logic                is_put;
  logic                put_wr;
  logic [CW-1:0]       put_chan;
  logic                stall;
  logic [NUM_CHAN-1:0] push;
  logic [NUM_CHAN-1:0] pop;
  logic [NUM_CHAN-1:0] empty;
  logic [NUM_CHAN-1:0] full;
  logic [NUM_CHAN-1:0] full_q;
  logic [CNTW-1:0]     cnt  [NUM_CHAN];
  fifo_entry_t         head [NUM_CHAN];
  fifo_entry_t         push_ent;
  logic [31:0]         rd_val;
  arb_state_e          state;
  logic [CW-1:0]       rr_ptr;
  logic [CW-1:0]       cand;
  logic [CW-1:0]       pick_chan;
  logic                pick_vld;

`ifdef HOST_IO_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 32'd1;
  end
`else
  assign out_ts_o = '0;
`endif

  assign off      = data_addr_i[11:0];
  assign hit      = (data_addr_i[31:12] == BASE_ADDR[31:12]);
  // Offsets below PUTCHAR_OFF wrap to a large index and fall out of range.
  assign put_idx  = (off - PUTCHAR_OFF) >> 2;
  assign is_put   = (off[1:0] == 2'b00) && (put_idx < 12'(NUM_CHAN));
  assign put_chan = put_idx[CW-1:0];
  assign put_wr   = data_we_i & is_put;
  assign stall    = put_wr & (full[put_chan] | full_q[put_chan]);

  assign data_gnt_o = data_req_i & hit & ~stall;

  always_comb begin
    push_ent      = '0;
    push_ent.char = data_wdata_i[7:0];
`ifdef HOST_IO_TIMESTAMP_EN
    push_ent.ts   = ts_cnt;
`endif
  end

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_chan
    assign push[g] = data_gnt_o & put_wr & data_be_i[0] & (put_chan == CW'(g));
    assign pop[g]  = (state == OFFER) & out_ready_i & (out_chan_o == CW'(g));

    host_io_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
      .clk      (clk_i),
      .rst      (rst_i),
      .push     (push[g]),
      .push_dat (push_ent),
      .pop      (pop[g]),
      .pop_dat  (head[g]),
      .count    (cnt[g]),
      .full     (full[g]),
      .empty    (empty[g]),
      .full_q   (full_q[g])
    );
  end

  always_comb begin
    rd_val = '0;
    case (off)
      STATUS_OFF: begin
        for (int c = 0; c < NUM_CHAN; c++) begin
          rd_val[c]   = (cnt[c] != '0);
          rd_val[8+c] = full[c];
        end
        rd_val[31] = exit_valid_o;
      end
      EXITCODE_OFF: rd_val = exit_code_o;
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
      exit_valid_o  <= 1'b0;
      exit_code_o   <= '0;
    end else begin
      data_rvalid_o <= data_gnt_o;
      data_rdata_o  <= (data_gnt_o && !data_we_i) ? rd_val : '0;
      if (data_gnt_o && data_we_i && (off == TOHOST_OFF) &&
          (data_be_i == 4'hF) && !exit_valid_o) begin
        exit_valid_o <= 1'b1;
        exit_code_o  <= data_wdata_i;
      end
    end
  end

  // First non-empty channel at or after rr_ptr.
  always_comb begin
    pick_vld  = 1'b0;
    pick_chan = rr_ptr;
    cand      = rr_ptr;
    for (int i = 0; i < NUM_CHAN; i++) begin
      cand = CW'((int'(rr_ptr) + i) % NUM_CHAN);
      if (!pick_vld && !empty[cand]) begin
        pick_vld  = 1'b1;
        pick_chan = cand;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      out_valid_o <= 1'b0;
      out_chan_o  <= '0;
      out_char_o  <= '0;
`ifdef HOST_IO_TIMESTAMP_EN
      out_ts_o    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state       <= OFFER;
            out_valid_o <= 1'b1;
            out_chan_o  <= pick_chan;
            out_char_o  <= head[pick_chan].char;
`ifdef HOST_IO_TIMESTAMP_EN
            out_ts_o    <= head[pick_chan].ts;
`endif
          end
        end
        OFFER: begin
          if (out_ready_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
            rr_ptr      <= (out_chan_o == CW'(NUM_CHAN - 1)) ? '0 : out_chan_o + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_io_mailbox.sv
// Directed bench for host_io_mailbox (default build, NUM_CHAN=2, FIFO_DEPTH=8).
module tb_host_io_mailbox;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [0:0]  out_chan_o;
  logic [7:0]  out_char_o;
  logic [31:0] out_ts_o;
  logic        exit_valid_o;
  logic [31:0] exit_code_o;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  q_char [$];
  logic [0:0]  q_chan [$];
  logic [31:0] rd;

  host_io_mailbox #(
    .NUM_CHAN   (2),
    .FIFO_DEPTH (8),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .data_req_i    (data_req_i),
    .data_addr_i   (data_addr_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_wdata_i  (data_wdata_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_chan_o    (out_chan_o),
    .out_char_o    (out_char_o),
    .out_ts_o      (out_ts_o),
    .exit_valid_o  (exit_valid_o),
    .exit_code_o   (exit_code_o)
  );

  always #5 clk_i = ~clk_i;

  // Record every character handed over (valid & ready seen mid-cycle pops at the next edge).
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      q_chan.push_back(out_chan_o);
      q_char.push_back(out_char_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, input string tag);
    int n;
    n = 0;
    @(posedge clk_i); #1;
    data_req_i = 1'b1; data_addr_i = addr; data_we_i = 1'b1;
    data_be_i = be; data_wdata_i = wd;
    @(negedge clk_i);
    while (data_gnt_o !== 1'b1 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, " gnt"}, 32'(data_gnt_o), 32'd1);
    @(posedge clk_i); #1;
    data_req_i = 1'b0; data_we_i = 1'b0;
    @(negedge clk_i);
    check({tag, " rvalid"}, 32'(data_rvalid_o), 32'd1);
    check({tag, " wr rdata"}, data_rdata_o, 32'd0);
  endtask

  task automatic bus_read(input logic [31:0] addr, input string tag, output logic [31:0] data);
    int n;
    n = 0;
    @(posedge clk_i); #1;
    data_req_i = 1'b1; data_addr_i = addr; data_we_i = 1'b0; data_be_i = 4'hF;
    @(negedge clk_i);
    while (data_gnt_o !== 1'b1 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, " gnt"}, 32'(data_gnt_o), 32'd1);
    @(posedge clk_i); #1;
    data_req_i = 1'b0;
    @(negedge clk_i);
    check({tag, " rvalid"}, 32'(data_rvalid_o), 32'd1);
    data = data_rdata_o;
  endtask

  initial begin
    rst_i = 1'b1; data_req_i = 1'b0; data_addr_i = '0; data_we_i = 1'b0;
    data_be_i = 4'h0; data_wdata_i = '0; out_ready_i = 1'b1;

    #2;
    check("rst rvalid", 32'(data_rvalid_o), 32'd0);
    check("rst rdata", data_rdata_o, 32'd0);
    check("rst out_valid", 32'(out_valid_o), 32'd0);
    check("rst exit_valid", 32'(exit_valid_o), 32'd0);
    check("rst exit_code", exit_code_o, 32'd0);
    check("rst out_ts", out_ts_o, 32'd0);
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;

    // Single character on channel 0.
    bus_write(BASE + 32'h10, 32'h48, 4'hF, "put0 H");
    check("H not yet valid", 32'(out_valid_o), 32'd0);
    @(negedge clk_i);
    check("H valid", 32'(out_valid_o), 32'd1);
    check("H chan", 32'(out_chan_o), 32'd0);
    check("H char", 32'(out_char_o), 32'h48);
    @(negedge clk_i);
    check("H popped", 32'(out_valid_o), 32'd0);

    // Address outside the window.
    @(posedge clk_i); #1;
    data_req_i = 1'b1; data_addr_i = 32'h0002_0004; data_we_i = 1'b0;
    @(negedge clk_i);
    check("miss gnt", 32'(data_gnt_o), 32'd0);
    @(posedge clk_i); #1;
    data_req_i = 1'b0;
    @(negedge clk_i);
    check("miss rvalid", 32'(data_rvalid_o), 32'd0);

    // Fill channel 1, then stall a ninth write.
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) bus_write(BASE + 32'h14, 32'h61 + 32'(i), 4'hF, "fill1");
    bus_read(BASE + 32'h004, "status full", rd);
    check("status full val", rd, 32'h0000_0202);
    @(posedge clk_i); #1;
    data_req_i = 1'b1; data_addr_i = BASE + 32'h14; data_we_i = 1'b1;
    data_be_i = 4'hF; data_wdata_i = 32'h69;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("full stall gnt", 32'(data_gnt_o), 32'd0);
    end
    @(posedge clk_i); #1;
    q_chan.delete(); q_char.delete();
    out_ready_i = 1'b1;
    @(negedge clk_i);
    check("stall pop cycle gnt", 32'(data_gnt_o), 32'd0);
    @(negedge clk_i);
    check("stall pop+1 gnt", 32'(data_gnt_o), 32'd0);
    @(negedge clk_i);
    check("stall pop+2 gnt", 32'(data_gnt_o), 32'd1);
    @(posedge clk_i); #1;
    data_req_i = 1'b0; data_we_i = 1'b0;
    @(negedge clk_i);
    check("ninth rvalid", 32'(data_rvalid_o), 32'd1);
    repeat (30) @(negedge clk_i);
    check("ch1 drain count", 32'(q_char.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      check("ch1 char", (i < q_char.size()) ? 32'(q_char[i]) : 32'hxxxx_xxxx, 32'h61 + 32'(i));
      check("ch1 chan", (i < q_chan.size()) ? 32'(q_chan[i]) : 32'hxxxx_xxxx, 32'd1);
    end

    // Round-robin between two loaded channels.
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    q_chan.delete(); q_char.delete();
    for (int i = 0; i < 3; i++) bus_write(BASE + 32'h10, 32'h30 + 32'(i), 4'hF, "rr ch0");
    for (int i = 0; i < 3; i++) bus_write(BASE + 32'h14, 32'h40 + 32'(i), 4'hF, "rr ch1");
    @(posedge clk_i); #1;
    out_ready_i = 1'b1;
    repeat (20) @(negedge clk_i);
    check("rr count", 32'(q_char.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check("rr chan", (i < q_chan.size()) ? 32'(q_chan[i]) : 32'hxxxx_xxxx, 32'(i % 2));
      check("rr char", (i < q_char.size()) ? 32'(q_char[i]) : 32'hxxxx_xxxx,
            ((i % 2) == 0) ? 32'h30 + 32'(i / 2) : 32'h40 + 32'(i / 2));
    end

    // Ignored writes and unmapped reads.
    bus_write(BASE + 32'h000, 32'hDEAD_BEEF, 4'h3, "tohost partial");
    check("partial exit_valid", 32'(exit_valid_o), 32'd0);
    bus_read(BASE + 32'h7FC, "rd 7fc", rd);
    check("rd 7fc val", rd, 32'd0);
    bus_write(BASE + 32'h10, 32'h55, 4'hE, "put be0=0");
    repeat (3) @(negedge clk_i);
    check("be0=0 no char", 32'(out_valid_o), 32'd0);
    bus_read(BASE + 32'h004, "status idle", rd);
    check("status idle val", rd, 32'd0);

    // Sticky exit code.
    bus_write(BASE + 32'h000, 32'h0000_0000, 4'hF, "tohost 0");
    check("exit_valid set", 32'(exit_valid_o), 32'd1);
    check("exit_code 0", exit_code_o, 32'd0);
    bus_write(BASE + 32'h000, 32'h0000_0001, 4'hF, "tohost 1");
    check("exit_valid sticky", 32'(exit_valid_o), 32'd1);
    check("exit_code sticky", exit_code_o, 32'd0);
    bus_read(BASE + 32'h004, "status exit", rd);
    check("status exit val", rd, 32'h8000_0000);
    bus_read(BASE + 32'h008, "exitcode", rd);
    check("exitcode val", rd, 32'd0);

    // Reset while offering with four characters buffered.
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) bus_write(BASE + 32'h10, 32'h70 + 32'(i), 4'hF, "pre-rst");
    repeat (2) @(negedge clk_i);
    check("pre-rst valid", 32'(out_valid_o), 32'd1);
    check("pre-rst char", 32'(out_char_o), 32'h70);
    rst_i = 1'b1;
    #1;
    check("rst out_valid async", 32'(out_valid_o), 32'd0);
    check("rst exit_valid async", 32'(exit_valid_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    q_chan.delete(); q_char.delete();
    out_ready_i = 1'b1;
    repeat (10) @(negedge clk_i);
    check("post-rst no chars", 32'(q_char.size()), 32'd0);
    bus_read(BASE + 32'h004, "status post-rst", rd);
    check("status post-rst val", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
